// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer between the core and data memory.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the live FIFO entries for load forwarding.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  sb_entry_t [DEPTH-1:0]         entries,
    input  logic [DEPTH-1:0]              valid,
    input  logic [$clog2(DEPTH)-1:0]      head,
    input  logic [29:0]                   probe,
    output logic                          hit,
    output logic [31:0]                   data
);
    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW-1:0] idx;

    // Walk oldest to youngest so the last match seen wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTRW'(k);
            if (valid[idx] && entries[idx].waddr == probe) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues core stores, drains them in order, forwards to loads.
// Define STORE_BUFFER_COALESCE_EN to merge a store into the newest entry on address match.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata
);
    localparam int PTRW = $clog2(DEPTH);
    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    sb_entry_t [DEPTH-1:0] entries;
    logic [PTRW-1:0]       head, tail;
    logic [PTRW:0]         count;
    logic [DEPTH-1:0]      valid;
    logic                  full, enq, deq, coalesce, hit;
    logic [31:0]           fwd_data;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign full       = (count == FULL_CNT);
    assign mem_wvalid = (count != '0);
    assign deq        = mem_wvalid & mem_wready;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PTRW-1:0] newest;
    assign newest = tail - PTRW'(1);
    // Merging into a head that is leaving this cycle would lose the data.
    assign coalesce = cpu_we && mem_wvalid
                      && (entries[newest].waddr == cpu_addr[31:2])
                      && !((count == (PTRW+1)'(1)) && deq);
`else
    assign coalesce = 1'b0;
`endif

    assign stall = cpu_we & full & ~coalesce;
    assign enq   = cpu_we & ~stall & ~coalesce;

    assign mem_waddr = {entries[head].waddr, 2'b00};
    assign mem_wdata = entries[head].data;
    assign mem_raddr = {cpu_addr[31:2], 2'b00};

    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [PTRW-1:0] age;
        assign age      = PTRW'(i) - head;
        assign valid[i] = ({1'b0, age} < count);
    end

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .probe   (cpu_addr[31:2]),
        .hit     (hit),
        .data    (fwd_data)
    );

    assign cpu_rdata = hit ? fwd_data : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTRW'(1);
            if (deq) head <= head + PTRW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTRW+1)'(1);
                2'b01:   count <= count - (PTRW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is only meaningful under the valid mask, so it is never reset.
    always_ff @(posedge clk) begin
        if (enq) entries[tail] <= '{waddr: cpu_addr[31:2], data: cpu_wdata};
`ifdef STORE_BUFFER_COALESCE_EN
        if (coalesce) entries[newest].data <= cpu_wdata;
`endif
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries; SHALL be a power of 2, minimum 2.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_we  input  1  core store request (core memwrite).
REQ-005 cpu_addr  input  32  core byte address (core aluout); bits [1:0] SHALL be ignored.
REQ-006 cpu_wdata  input  32  core store data.
REQ-007 cpu_rdata  output  32  load data returned to the core.
REQ-008 stall  output  1  core SHALL hold PC and its outputs while high.
REQ-009 mem_wvalid  output  1  write request to data memory.
REQ-010 mem_wready  input  1  data memory accepts the write this cycle.
REQ-011 mem_waddr  output  32  write byte address; bits [1:0] SHALL be 0.
REQ-012 mem_wdata  output  32  write data.
REQ-013 mem_raddr  output  32  combinational read address, equal to {cpu_addr[31:2],2'b00}.
REQ-014 mem_rdata  input  32  combinational read data from data memory.

Function
REQ-015 FIFO of DEPTH entries {word address [29:0], data [31:0]}, with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH and a count of log2(DEPTH)+1 bits.
REQ-016 Enqueue SHALL occur when cpu_we=1 and stall=0, writing the entry at tail on the clock edge.
REQ-017 stall SHALL equal cpu_we & (count==DEPTH), combinational, independent of mem_wready.
REQ-018 mem_wvalid SHALL equal (count!=0); mem_waddr/mem_wdata SHALL present the head entry.
REQ-019 Dequeue SHALL occur when mem_wvalid & mem_wready; head advances on that edge.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged. When full, enqueue is refused that cycle even if a dequeue occurs (stall is held one extra cycle).
REQ-021 mem_waddr/mem_wdata SHALL remain stable while mem_wvalid=1 and mem_wready=0.
REQ-022 Load forwarding: if any valid entry matches cpu_addr[31:2], cpu_rdata SHALL be the data of the youngest matching entry; otherwise cpu_rdata SHALL be mem_rdata. Zero-cycle latency.
REQ-023 A store enqueued in cycle N SHALL NOT affect cpu_rdata in cycle N; it SHALL be visible from cycle N+1.
REQ-024 Stores SHALL reach memory in program order (except as REQ-029 permits).

Reset
REQ-025 reset SHALL asynchronously clear head, tail and count. Outputs after reset: mem_wvalid=0, stall=0, cpu_rdata=mem_rdata.
REQ-026 Reset mid-drain SHALL discard all buffered entries; mem_wvalid SHALL drop immediately. Entry storage needs no reset.

Configuration
REQ-027 Macro STORE_BUFFER_COALESCE_EN SHALL select whether write coalescing is compiled in.
REQ-028 Without the macro, every accepted store SHALL allocate a new entry.
REQ-029 With the macro, a store whose word address matches the newest entry SHALL overwrite that entry's data and not allocate. This applies unless that entry is the head and is being dequeued this cycle, in which case the store allocates normally. A coalesced store SHALL NOT stall even when the buffer is full.

Structure
REQ-030 Package store_buffer_pkg SHALL hold the entry typedef (waddr, data) and the DEPTH default constant.
REQ-031 Sub-module sb_fwd_match SHALL perform the youngest-match priority search for REQ-022 (inputs: entries, valid mask, head, probe address; outputs: hit, data).

Verification
REQ-032 Idle: reset, cpu_we=1 addr 0x54 data 0x7 with mem_wready=0 -> next cycle mem_wvalid=1, mem_waddr=0x54, mem_wdata=0x7, and load of 0x54 returns 0x7.
REQ-033 Full: mem_wready=0, four stores to 0x0/0x4/0x8/0xC, fifth store to 0x10 -> stall=1. Release mem_wready=1 for one cycle -> stall=1 that cycle, 0x10 enqueued the next cycle. Memory receives writes in order 0x0, 0x4, 0x8, 0xC, 0x10.
REQ-034 Forwarding order: stores 0x20<-0xA then 0x20<-0xB, mem_wready=0 -> load 0x20 returns 0xB. Load 0x24 returns mem_rdata.
REQ-035 Simultaneous: count=2, enqueue and dequeue in the same cycle -> count stays 2, pointers advance and wrap past DEPTH-1 correctly.
REQ-036 Reset mid-drain: 3 entries queued, reset pulsed asynchronously between edges -> mem_wvalid=0 immediately, stall=0, no further memory writes.
REQ-037 Coalescing, with STORE_BUFFER_COALESCE_EN defined: two consecutive stores to 0x40 (0x1 then 0x2), mem_wready=0 -> count=1 holding 0x2. Without the macro -> count=2.
